// File: rtl/wb_trace_collector.sv
// Buffers core write-back events (GRF, then DM) in program order as a valid/ready record stream.
// One-cycle event-to-output latency; a full FIFO drops late events (sticky ovf, saturating drop_cnt) rather than stalling the core.
module wb_trace_collector #(
  parameter int DEPTH       = 16,
  parameter bit FILTER_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grf_we,
  input  logic [31:0]              grf_pc,
  input  logic [4:0]               grf_addr,
  input  logic [31:0]              grf_data,
  input  logic                     dm_we,
  input  logic [31:0]              dm_pc,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_type,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic        typ;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] dm_slot;

  logic          g;
  logic          d;
  logic          pop;
  logic          acc_g;
  logic          acc_d;
  logic [LW:0]   free;
  logic [LW:0]   need_d;
  logic [1:0]    n_push;
  logic [1:0]    n_drop;
  logic [LW-1:0] level_nxt;
  logic [16:0]   drop_sum;
  rec_t          grf_rec;
  rec_t          dm_rec;
  rec_t          head;

  assign g   = grf_we & ~(FILTER_ZERO & (grf_addr == 5'd0));
  assign d   = dm_we;
  assign pop = out_valid & out_ready;

  // A same-cycle pop frees a slot, so a full FIFO still takes one event while draining.
  assign free   = (LW+1)'(DEPTH) - {1'b0, level} + {{LW{1'b0}}, pop};
  assign acc_g  = g & (free != '0);
  assign need_d = acc_g ? (LW+1)'(2) : (LW+1)'(1);
  assign acc_d  = d & (free >= need_d);

  assign n_push    = {1'b0, acc_g} + {1'b0, acc_d};
  assign n_drop    = {1'b0, g & ~acc_g} + {1'b0, d & ~acc_d};
  assign level_nxt = level + LW'(n_push) - LW'(pop);
  assign drop_sum  = {1'b0, drop_cnt} + 17'(n_drop);
  assign dm_slot   = wr_ptr + AW'(acc_g);

  assign grf_rec = '{typ: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_data};
  assign dm_rec  = '{typ: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_data};

  // Storage is deliberately left uncleared; pointers held in reset keep it unobservable.
  always_ff @(posedge clk) begin
    if (acc_g) mem[wr_ptr]  <= grf_rec;
    if (acc_d) mem[dm_slot] <= dm_rec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop);
      level  <= level_nxt;
      if (n_drop != 2'd0) ovf <= 1'b1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (level != '0);
  assign out_type  = head.typ;
  assign out_pc    = head.pc;
  assign out_addr  = head.addr;
  assign out_data  = head.data;

endmodule

// File: doc/wb_trace_collector.md
# wb_trace_collector

Captures the architectural write-back events of the `mips` core (register-file writes and data-memory writes) and hands them out, in program order, as a buffered valid/ready record stream. It sits beside the core in simulation and FPGA builds and replaces ad-hoc `$display` tracing. A checker, UART dumper, or bench monitor reads the trace through it without stalling the core. The block is the reading end of the core's write-back trace.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `FILTER_ZERO`, 1: when 1, GRF writes to register 0 are discarded (not counted as drops).

Ports:
- `clk` in 1: the single clock; all logic samples on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `grf_we` in 1: core writes the register file this cycle.
- `grf_pc` in 32: PC of the writing instruction.
- `grf_addr` in 5: destination register.
- `grf_data` in 32: value written.
- `dm_we` in 1: core writes data memory this cycle.
- `dm_pc` in 32: PC of the storing instruction.
- `dm_addr` in 32: byte address (word aligned by core).
- `dm_data` in 32: value stored.
- `out_valid` out 1: record available.
- `out_ready` in 1: consumer accepts record.
- `out_type` out 1: 0 = GRF record, 1 = DM record.
- `out_pc` out 32: record PC.
- `out_addr` out 32: DM address, or GRF index zero-extended.
- `out_data` out 32: record data.
- `level` out log2(DEPTH)+1: current FIFO occupancy.
- `ovf` out 1: sticky overflow flag.
- `drop_cnt` out 16: saturating count of dropped events.

## Operation
- Each record is 97 bits: {type, pc, addr, data}. Records are stored in a circular FIFO with read and write pointers of log2(DEPTH) bits and an occupancy counter.
- Event qualification per cycle: `g = grf_we & ~(FILTER_ZERO & grf_addr==0)` and `d = dm_we`.
- Up to two pushes per cycle. When both occur, the GRF record goes to the lower slot (it is popped first), then the DM record.
- Free space in a cycle is `DEPTH - level + pop`, where `pop = out_valid & out_ready`. A same-cycle pop frees a slot.
- Full or overflow handling:
  - When free space < number of qualified events, events are accepted in priority order (GRF, then DM) until space runs out.
  - Each rejected event increments `drop_cnt`, which saturates at 16'hFFFF.
  - Any rejection sets `ovf`. `ovf` clears only on reset.
- Output: `out_valid = (level != 0)`. The `out_*` fields show the head entry directly from the storage array. They are stable while `out_valid & ~out_ready`.
- Pointers wrap modulo DEPTH. The level update is `level + pushes - pop`, and it never exceeds DEPTH.
- Reset (asynchronous, any time, including mid-burst):
  - Pointers, `level`, `ovf`, and `drop_cnt` go to 0, so `out_valid` = 0. Buffered records are lost.
  - The storage array is not cleared, so the `out_type`/`out_pc`/`out_addr`/`out_data` values are don't-care while `out_valid` = 0.
  - No events are accepted while `reset` = 0.

## Timing
- Event-to-output latency is 1 cycle. An event sampled at edge N makes `out_valid` high after edge N when the FIFO was empty.
- Throughput is 1 record popped per cycle. Sustained input of 2 events per cycle fills the FIFO at net +1 per cycle.
- `level`, `ovf`, and `drop_cnt` are registered and update on the same edge as the push or pop that changes them.
- The block has no combinational path from `out_ready` to the `out_*` outputs or to `out_valid`.

## Test plan
- **Reset values:** hold `reset`=0 and toggle `grf_we` -> `out_valid`=0, `level`=0, `ovf`=0, `drop_cnt`=0. Deassert `reset` mid-cycle -> no spurious record.
- **Single GRF event:**
  - Stimulus: `grf_we`=1, `pc`=0x3000, `addr`=8, `data`=0x1234 for one cycle, `out_ready`=1.
  - Response: next cycle `out_valid`=1, type 0, `out_addr`=8, `out_data`=0x1234. The following cycle `level`=0.
- **Zero filter:** `grf_addr`=0 with FILTER_ZERO=1 -> no record and `drop_cnt` unchanged. With FILTER_ZERO=0 -> one record with `out_addr`=0.
- **Simultaneous events:**
  - Stimulus: `grf_we` and `dm_we` in one cycle (`dm_addr`=0x10, `dm_data`=0xAB).
  - Response: GRF record is popped first, then the DM record (type 1, `addr`=0x10). `level` peaks at 2.
- **Overflow and wrap:**
  - Stimulus: `out_ready`=0, then 17 single events with DEPTH=16.
  - Response: `level`=16, `ovf`=1, `drop_cnt`=1. Draining returns the first 16 in order. A further 20 events with `out_ready`=1 pass in order across pointer wrap.
- **Full with pop:**
  - Stimulus: FIFO full, `out_ready`=1, one event in the same cycle.
  - Response: event accepted, `level` stays 16, `drop_cnt` unchanged. With two events that cycle, the DM event is dropped and `drop_cnt` increments by 1.
